// File: rtl/store_narrow_rmw_if.sv
// Store-path bus bundle: datapath store request plus data-memory port.
// slave = the store unit, master = requester/memory side.
interface store_narrow_rmw_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              misaligned;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        output done, misaligned
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        input  done, misaligned
    );
endinterface

// File: rtl/store_narrow_rmw.sv
// Narrowing store unit: SB/SH/SW into a word memory without byte enables.
// Ports: clk, reset (sync, active high), bus (store_narrow_rmw_if.slave).
module store_narrow_rmw #(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic clk,
    input  logic reset,
    store_narrow_rmw_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_ERR
    } state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        req_err;
    logic [1:0]  blane;
    logic        hlane;
    logic [31:0] merged;

    always_comb begin
        req_err = 1'b0;
        unique case (bus.req_size)
            SZ_B:    req_err = 1'b0;
            SZ_H:    req_err = bus.req_addr[0];
            SZ_W:    req_err = (bus.req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    // Lane of the addressed byte/halfword inside the memory word.
    always_comb begin
        if (BIG_ENDIAN) begin
            blane = 2'd3 - addr_q[1:0];
            hlane = ~addr_q[1];
        end else begin
            blane = addr_q[1:0];
            hlane = addr_q[1];
        end
    end

    always_comb begin
        merged = bus.mem_rdata;
        unique case (size_q)
            SZ_B:    merged[{blane, 3'b000} +: 8]  = data_q[7:0];
            SZ_H:    merged[{hlane, 4'b0000} +: 16] = data_q;
            default: merged = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    data_d = bus.req_data[15:0];
                    size_d = bus.req_size;
                    if (req_err) begin
                        state_d = S_ERR;
                    end else if (bus.req_size == SZ_W) begin
                        // Full word needs no read; it is the merged word.
                        wdata_d = bus.req_data;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = S_MERGE;
            S_MERGE: begin
                wdata_d = merged;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_rd_en  = (state_q == S_READ);
    assign bus.mem_wr_en  = (state_q == S_WRITE);
    assign bus.mem_wdata  = wdata_q;
    assign bus.done       = (state_q == S_WRITE);
    assign bus.misaligned = (state_q == S_ERR);
endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: little- and big-endian instances driven
// together, each backed by a word memory, checked against byte-level models.
module tb_store_narrow_rmw;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];
    logic [7:0]  ref0 [256];
    logic [7:0]  ref1 [256];

    always #5 clk = ~clk;

    store_narrow_rmw_if #(.ADDR_W(32)) b0 ();
    store_narrow_rmw_if #(.ADDR_W(32)) b1 ();

    assign b0.req_valid = req_valid;
    assign b0.req_addr  = req_addr;
    assign b0.req_data  = req_data;
    assign b0.req_size  = req_size;
    assign b1.req_valid = req_valid;
    assign b1.req_addr  = req_addr;
    assign b1.req_data  = req_data;
    assign b1.req_size  = req_size;

    store_narrow_rmw #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0.slave)
    );

    store_narrow_rmw #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    function automatic logic [7:0] init_byte(int a);
        if (a >= 16 && a < 20) return 8'h11;
        if (a == 32 || a == 33) return 8'hAA;
        if (a == 34 || a == 35) return 8'hBB;
        return 8'(a * 37 + 5);
    endfunction

    // Memories: one-cycle read latency, write on the strobe edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                mem0[i] <= {init_byte(4*i+3), init_byte(4*i+2),
                            init_byte(4*i+1), init_byte(4*i)};
                mem1[i] <= {init_byte(4*i), init_byte(4*i+1),
                            init_byte(4*i+2), init_byte(4*i+3)};
            end
        end else begin
            if (b0.mem_rd_en) b0.mem_rdata <= mem0[b0.mem_addr[7:2]];
            if (b0.mem_wr_en) mem0[b0.mem_addr[7:2]] <= b0.mem_wdata;
            if (b1.mem_rd_en) b1.mem_rdata <= mem1[b1.mem_addr[7:2]];
            if (b1.mem_wr_en) mem1[b1.mem_addr[7:2]] <= b1.mem_wdata;
        end
    end

    task automatic init_ref();
        for (int i = 0; i < 256; i++) begin
            ref0[i] = init_byte(i);
            ref1[i] = init_byte(i);
        end
    endtask

    // Byte-addressed memory semantics: LE puts the low byte at the lowest
    // address, BE puts the most significant byte there.
    task automatic ref_store(int a, logic [31:0] d, logic [1:0] s);
        int n;
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            ref0[a+i] = d[8*i +: 8];
            ref1[a+i] = d[8*(n-1-i) +: 8];
        end
    endtask

    function automatic logic [31:0] le_word(int w);
        return {ref0[w+3], ref0[w+2], ref0[w+1], ref0[w]};
    endfunction

    function automatic logic [31:0] be_word(int w);
        return {ref1[w], ref1[w+1], ref1[w+2], ref1[w+3]};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Strobe vector {rd, wr, done, misaligned, ready} for both instances.
    task automatic chk_strobes(string tag, logic [4:0] exp);
        chk({tag, "_le"}, 32'({b0.mem_rd_en, b0.mem_wr_en, b0.done,
                               b0.misaligned, b0.req_ready}), 32'(exp));
        chk({tag, "_be"}, 32'({b1.mem_rd_en, b1.mem_wr_en, b1.done,
                               b1.misaligned, b1.req_ready}), 32'(exp));
    endtask

    // Called just after a falling edge with the unit idle.
    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input bit hold,
                         input logic [31:0] na, input logic [31:0] nd,
                         input logic [1:0] ns);
        bit err;
        int n;
        int w;
        logic [4:0] exp;
        err = (s == 2'd3) || (s == 2'd1 && a[0]) ||
              (s == 2'd2 && a[1:0] != 2'b00);
        n = (err || s == 2'd2) ? 1 : 3;
        w = int'(a[7:0]) & 32'hFC;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        chk_strobes("idle", 5'b00001);
        @(posedge clk);
        #1;
        if (hold) begin
            req_addr = na;
            req_data = nd;
            req_size = ns;
        end else begin
            req_valid = 1'b0;
        end
        if (!err) ref_store(int'(a[7:0]), d, s);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            exp = {k == 1 && !err && s != 2'd2, k == n && !err,
                   k == n && !err, k == 1 && err, k == n + 1};
            chk_strobes($sformatf("a%h_s%0d_k%0d", a, s, k), exp);
            if (k == n && !err) begin
                chk("maddr_le", b0.mem_addr, {a[31:2], 2'b00});
                chk("maddr_be", b1.mem_addr, {a[31:2], 2'b00});
                chk("wdata_le", b0.mem_wdata, le_word(w));
                chk("wdata_be", b1.mem_wdata, be_word(w));
            end
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        logic [1:0]  rs;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        init_ref();
        chk_strobes("reset", 5'b00001);
        chk("rst_maddr", b0.mem_addr, 32'h0);
        chk("rst_wdata", b1.mem_wdata, 32'h0);

        store(32'h13, 32'hFFFF_FF88, 2'd0, 1'b0, '0, '0, '0);
        chk("sb_mem_le", mem0[4], 32'h8811_1111);
        chk("sb_mem_be", mem1[4], 32'h1111_1188);

        store(32'h20, 32'h0000_1001, 2'd1, 1'b0, '0, '0, '0);
        chk("sh_mem_be", mem1[8], 32'h1001_BBBB);
        chk("sh_mem_le", mem0[8], 32'hBBBB_1001);

        store(32'h10, 32'h1234_5678, 2'd2, 1'b0, '0, '0, '0);
        chk("sw_mem_le", mem0[4], 32'h1234_5678);
        chk("sw_mem_be", mem1[4], 32'h1234_5678);

        store(32'h21, 32'hDEAD_BEEF, 2'd1, 1'b0, '0, '0, '0);
        store(32'h22, 32'hDEAD_BEEF, 2'd2, 1'b0, '0, '0, '0);
        store(32'h40, 32'hDEAD_BEEF, 2'd3, 1'b0, '0, '0, '0);

        store(32'h31, 32'hCAFE_F00D, 2'd0, 1'b1,
              32'h34, 32'h5566_7788, 2'd2);
        store(32'h34, 32'h5566_7788, 2'd2, 1'b0, '0, '0, '0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom();
            rd = $urandom();
            rs = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
            store(ra, rd, rs, 1'b0, '0, '0, '0);
        end

        for (int i = 0; i < 64; i++) begin
            chk($sformatf("sweep_le_%0d", i), mem0[i], le_word(4*i));
            chk($sformatf("sweep_be_%0d", i), mem1[i], be_word(4*i));
        end

        req_valid = 1'b1;
        req_addr  = 32'h44;
        req_data  = 32'h0000_00A5;
        req_size  = 2'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk_strobes("mid_read", 5'b10000);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        init_ref();
        @(negedge clk);
        chk_strobes("mid_rst1", 5'b00001);
        @(negedge clk);
        chk_strobes("mid_rst2", 5'b00001);

        store(32'h48, 32'h0BAD_F00D, 2'd2, 1'b0, '0, '0, '0);
        chk("post_rst_le", mem0[18], 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
